// File: rtl/feed_pkg.sv
// -----------------------------------------------------------------------------
// feed_pkg
//
// Shared types and defaults for the feed-port arbitration blocks.
//
//   arb_state_t            : packet arbiter state (IDLE / STREAM / DRAIN)
//   DEFAULT_NUM_PORTS      : default number of MAC receive ports sharing a parser
//   DEFAULT_MAX_PKT_BYTES  : default per-packet byte limit (8 preamble/SFD + 1522)
// -----------------------------------------------------------------------------
package feed_pkg;

   localparam int DEFAULT_NUM_PORTS     = 4;
   localparam int DEFAULT_MAX_PKT_BYTES = 1530;

   // IDLE   : arbitration cycle, nothing accepted
   // STREAM : granted port forwarded byte by byte to the parser
   // DRAIN  : remainder of a truncated packet is consumed and dropped
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } arb_state_t;

endpackage : feed_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Combinational rotate-priority picker. The search starts at last_grant+1 and
// walks upward, wrapping modulo NUM_PORTS, so the most recently served port has
// the lowest priority on the next pick. Used by any block that shares a single
// resource between several requesters.
//
// Ports:
//   req        in  NUM_PORTS  request vector, one bit per requester
//   last_grant in  PORT_W     index of the requester served most recently
//   winner     out PORT_W     selected requester (0 when nothing is requested)
//   any_req    out 1          at least one request bit is set
// -----------------------------------------------------------------------------
module rr_arbiter
   import feed_pkg::*;
#(
   parameter  int NUM_PORTS = DEFAULT_NUM_PORTS,
   localparam int PORT_W    = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_W-1:0]    last_grant,
   output logic [PORT_W-1:0]    winner,
   output logic                 any_req
);

   assign any_req = |req;

   // NOTE: every variable written here gets a value before any branch, so the
   // block stays purely combinational and no latch is inferred.
   always_comb begin : pick
      logic              found;
      logic [PORT_W-1:0] idx;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      // k runs 1..NUM_PORTS so last_grant itself is examined last.
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = PORT_W'((int'(last_grant) + k) % NUM_PORTS);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/feed_port_arbiter.sv
// -----------------------------------------------------------------------------
// feed_port_arbiter
//
// Packet-granular round-robin arbiter sharing one byte-stream parser between
// NUM_PORTS MAC receive ports. A port keeps the grant for a whole packet, so
// packets are never interleaved; each forwarded byte carries its source port.
// The parser cannot stall, so flow control is applied upstream via s_tready.
// Packets longer than MAX_PKT_BYTES (or missing tlast) are cut: the byte at the
// limit is forwarded with m_tlast, err_oversize pulses, and the rest of the
// packet is drained and dropped so a faulty link cannot hog the parser.
//
// Ports:
//   clk          in  1            clock
//   rst_n        in  1            asynchronous active-low reset
//   port_enable  in  NUM_PORTS    per-port arbitration enable
//   s_tdata      in  NUM_PORTS*8  input bytes, port i on [8i+7:8i]
//   s_tvalid     in  NUM_PORTS    per-port byte valid
//   s_tlast      in  NUM_PORTS    per-port last byte of packet
//   s_tready     out NUM_PORTS    per-port accept (one-hot or zero)
//   m_tdata      out 8            byte to parser
//   m_tvalid     out 1            byte valid to parser
//   m_tlast      out 1            last byte of forwarded packet
//   m_port       out PORT_W       source port of the current m_ byte
//   err_oversize out 1            one-cycle pulse on packet truncation
//   err_port     out PORT_W       port of the most recent truncation
//
// Timing: a request seen on an idle arbiter is arbitrated in cycle T, its first
// byte accepted in T+1 and presented on m_* in T+2. Consecutive packets are
// separated by exactly one m_tvalid-low cycle (the arbitration cycle).
// -----------------------------------------------------------------------------
module feed_port_arbiter
   import feed_pkg::*;
#(
   parameter  int NUM_PORTS     = DEFAULT_NUM_PORTS,
   parameter  int MAX_PKT_BYTES = DEFAULT_MAX_PKT_BYTES,
   localparam int PORT_W        = $clog2(NUM_PORTS),
   localparam int CNT_W         = $clog2(MAX_PKT_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_PORTS-1:0]   port_enable,
   input  logic [NUM_PORTS*8-1:0] s_tdata,
   input  logic [NUM_PORTS-1:0]   s_tvalid,
   input  logic [NUM_PORTS-1:0]   s_tlast,
   output logic [NUM_PORTS-1:0]   s_tready,
   output logic [7:0]             m_tdata,
   output logic                   m_tvalid,
   output logic                   m_tlast,
   output logic [PORT_W-1:0]      m_port,
   output logic                   err_oversize,
   output logic [PORT_W-1:0]      err_port
);

   localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(MAX_PKT_BYTES - 1);
   localparam logic [PORT_W-1:0] RESET_LAST = PORT_W'(NUM_PORTS - 1);

   arb_state_t          state;
   logic [PORT_W-1:0]   grant;
   logic [PORT_W-1:0]   last_grant;
   logic [CNT_W-1:0]    byte_cnt;

   logic [NUM_PORTS-1:0] req;
   logic [PORT_W-1:0]    winner;
   logic                 any_req;

   logic [7:0]           port_byte [NUM_PORTS];
   logic [7:0]           sel_data;
   logic                 sel_last;
   logic                 accept;

   // Enables only matter while arbitrating; a port disabled mid-packet keeps
   // its grant until the packet ends.
   assign req = s_tvalid & port_enable;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS)
   ) u_rr_arbiter (
      .req        (req),
      .last_grant (last_grant),
      .winner     (winner),
      .any_req    (any_req)
   );

   // Unpack the flat byte bus so the granted port can be selected by index.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         port_byte[i] = s_tdata[i*8 +: 8];
      end
   end

   assign sel_data = port_byte[grant];
   assign sel_last = s_tlast[grant];

   // Ready depends on state and grant only, never on s_tvalid, so there is no
   // combinational path from an input valid back to any ready.
   always_comb begin
      s_tready = '0;
      if (state != IDLE) begin
         s_tready[grant] = 1'b1;
      end
   end

   assign accept = s_tvalid[grant] && s_tready[grant];

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         last_grant   <= RESET_LAST;
         byte_cnt     <= '0;
         m_tdata      <= '0;
         m_tvalid     <= 1'b0;
         m_tlast      <= 1'b0;
         m_port       <= '0;
         err_oversize <= 1'b0;
         err_port     <= '0;
      end else begin
         err_oversize <= 1'b0;
         unique case (state)
            IDLE: begin
               m_tvalid <= 1'b0;
               m_tlast  <= 1'b0;
               if (any_req) begin
                  grant    <= winner;
                  byte_cnt <= '0;
                  state    <= STREAM;
               end
            end

            STREAM: begin
               if (accept) begin
                  m_tdata  <= sel_data;
                  m_tvalid <= 1'b1;
                  m_port   <= grant;
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  if (sel_last) begin
                     m_tlast    <= 1'b1;
                     last_grant <= grant;
                     state      <= IDLE;
                  end else if (byte_cnt == LAST_CNT) begin
                     // Byte at the limit without tlast: close the packet for
                     // the parser and drop whatever the port still sends.
                     m_tlast      <= 1'b1;
                     err_oversize <= 1'b1;
                     err_port     <= grant;
                     last_grant   <= grant;
                     state        <= DRAIN;
                  end else begin
                     m_tlast <= 1'b0;
                  end
               end else begin
                  // Input gap: grant is held, other ports stay blocked.
                  m_tvalid <= 1'b0;
                  m_tlast  <= 1'b0;
               end
            end

            DRAIN: begin
               m_tvalid <= 1'b0;
               m_tlast  <= 1'b0;
               if (accept && sel_last) begin
                  state <= IDLE;
               end
            end

            default: begin
               m_tvalid <= 1'b0;
               m_tlast  <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule : feed_port_arbiter

// File: tb/tb_feed_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_feed_port_arbiter
//
// Directed bench for feed_port_arbiter. Two instances share every input: one
// with the default packet limit and one with MAX_PKT_BYTES=16 for truncation.
// Both always agree on s_tready (STREAM and DRAIN both ready the granted port),
// so the stimulus follows the default instance's ready. Each cycle the outputs
// of both instances are logged; expected byte streams are built by hand.
// -----------------------------------------------------------------------------
module tb_feed_port_arbiter;

   localparam int NP = 4;

   typedef struct packed {
      logic       v;
      logic       l;
      logic [1:0] p;
      logic [7:0] d;
      logic       e;
      logic [1:0] ep;
   } obs_t;

   logic          clk;
   logic          rst_n;
   logic [NP-1:0] port_enable;
   logic [NP*8-1:0] s_tdata;
   logic [NP-1:0] s_tvalid;
   logic [NP-1:0] s_tlast;

   logic [NP-1:0] s_tready_a, s_tready_b;
   logic [7:0]    m_tdata_a, m_tdata_b;
   logic          m_tvalid_a, m_tvalid_b;
   logic          m_tlast_a, m_tlast_b;
   logic [1:0]    m_port_a, m_port_b;
   logic          err_oversize_a, err_oversize_b;
   logic [1:0]    err_port_a, err_port_b;

   feed_port_arbiter #(
      .NUM_PORTS     (NP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .port_enable  (port_enable),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .s_tready     (s_tready_a),
      .m_tdata      (m_tdata_a),
      .m_tvalid     (m_tvalid_a),
      .m_tlast      (m_tlast_a),
      .m_port       (m_port_a),
      .err_oversize (err_oversize_a),
      .err_port     (err_port_a)
   );

   feed_port_arbiter #(
      .NUM_PORTS     (NP),
      .MAX_PKT_BYTES (16)
   ) dut_small (
      .clk          (clk),
      .rst_n        (rst_n),
      .port_enable  (port_enable),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .s_tready     (s_tready_b),
      .m_tdata      (m_tdata_b),
      .m_tvalid     (m_tvalid_b),
      .m_tlast      (m_tlast_b),
      .m_port       (m_port_b),
      .err_oversize (err_oversize_b),
      .err_port     (err_port_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-port source buffers: {tlast, byte}
   logic [8:0] pmem [NP][512];
   int         wp [NP];
   int         rp [NP];
   bit         hold [NP];

   obs_t        log_a [$];
   obs_t        log_b [$];
   logic [10:0] exp_q [$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         if (!hold[i] && rp[i] != wp[i]) begin
            s_tvalid[i]        = 1'b1;
            s_tdata[i*8 +: 8]  = pmem[i][rp[i]][7:0];
            s_tlast[i]         = pmem[i][rp[i]][8];
         end else begin
            s_tvalid[i]        = 1'b0;
            s_tdata[i*8 +: 8]  = 8'h00;
            s_tlast[i]         = 1'b0;
         end
      end
   endtask

   task automatic push_pkt(input int p, input int n, input int base);
      for (int k = 0; k < n; k++) begin
         pmem[p][wp[p]] = {(k == n - 1), 8'(base + k)};
         wp[p]++;
      end
   endtask

   task automatic exp_pkt(input int p, input int n, input int base);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({(k == n - 1), 2'(p), 8'(base + k)});
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < NP; i++) s += wp[i] - rp[i];
      return s;
   endfunction

   // One clock: inputs were set #1 after the previous edge; outputs are
   // sampled #1 after this edge, then the next beat is driven.
   task automatic step();
      logic [NP-1:0] rdy;
      logic [NP-1:0] vld;
      rdy = s_tready_a;
      vld = s_tvalid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
         if (rdy[i] && vld[i]) rp[i]++;
      end
      log_a.push_back('{m_tvalid_a, m_tlast_a, m_port_a, m_tdata_a, err_oversize_a, err_port_a});
      log_b.push_back('{m_tvalid_b, m_tlast_b, m_port_b, m_tdata_b, err_oversize_b, err_port_b});
      drive();
   endtask

   task automatic run(input string tag, input int budget);
      int n = 0;
      while (pending() != 0 && n < budget) begin
         step();
         n++;
      end
      check({tag, "_all_accepted"}, pending(), 0);
      repeat (3) step();
   endtask

   task automatic clear_log();
      log_a.delete();
      log_b.delete();
      exp_q.delete();
   endtask

   // Compares the valid beats of one instance against exp_q.
   task automatic compare_stream(input bit use_b, input string tag);
      logic [10:0] got [$];
      int bad = 0;
      if (use_b) begin
         foreach (log_b[i]) if (log_b[i].v) got.push_back({log_b[i].l, log_b[i].p, log_b[i].d});
      end else begin
         foreach (log_a[i]) if (log_a[i].v) got.push_back({log_a[i].l, log_a[i].p, log_a[i].d});
      end
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         if (got[i] !== exp_q[i]) bad++;
      end
      check({tag, "_beats_wrong"}, bad, 0);
   endtask

   function automatic int count_err(input bit use_b);
      int c = 0;
      if (use_b) begin
         foreach (log_b[i]) if (log_b[i].e) c++;
      end else begin
         foreach (log_a[i]) if (log_a[i].e) c++;
      end
      return c;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gaps;
      rst_n       = 1'b0;
      port_enable = 4'hF;
      s_tdata     = '0;
      s_tvalid    = '0;
      s_tlast     = '0;
      for (int i = 0; i < NP; i++) begin
         wp[i] = 0; rp[i] = 0; hold[i] = 1'b0;
      end

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_tready",     s_tready_a, 0);
      check("rst_m_tvalid",     m_tvalid_a, 0);
      check("rst_m_tdata",      m_tdata_a, 0);
      check("rst_m_tlast",      m_tlast_a, 0);
      check("rst_m_port",       m_port_a, 0);
      check("rst_err_oversize", err_oversize_a, 0);
      check("rst_err_port",     err_port_a, 0);
      rst_n = 1'b1;
      step();
      step();
      check("idle_no_ready", s_tready_a, 0);

      // ---- 1: single 64-byte packet on port 0 ----
      clear_log();
      push_pkt(0, 64, 8'h00);
      drive();
      run("t1", 200);
      check("t1_arb_cycle_invalid", log_a[0].v, 0);
      check("t1_first_valid_t2",    {log_a[1].v, log_a[1].d}, {1'b1, 8'h00});
      exp_pkt(0, 64, 8'h00);
      compare_stream(0, "t1");
      exp_q.delete();
      exp_pkt(0, 16, 8'h00);
      compare_stream(1, "t1_small_trunc");
      check("t1_small_err_pulses", count_err(1), 1);

      // ---- 2: ports 0,1,2 request together after a fresh reset ----
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_log();
      push_pkt(0, 10, 8'h10);
      push_pkt(1, 10, 8'h20);
      push_pkt(2, 10, 8'h30);
      drive();
      run("t2", 200);
      exp_pkt(0, 10, 8'h10);
      exp_pkt(1, 10, 8'h20);
      exp_pkt(2, 10, 8'h30);
      compare_stream(0, "t2");
      check("t2_pkt0_end",   {log_a[10].v, log_a[10].l}, 2'b11);
      check("t2_gap0",       log_a[11].v, 0);
      check("t2_pkt1_start", {log_a[12].v, log_a[12].p}, {1'b1, 2'd1});
      check("t2_gap1",       log_a[22].v, 0);
      check("t2_pkt2_start", {log_a[23].v, log_a[23].p}, {1'b1, 2'd2});

      // ---- 3a: port 0 back-to-back, port 3 joins while port 0 streams ----
      clear_log();
      push_pkt(0, 4, 8'h40);
      push_pkt(0, 4, 8'h50);
      drive();
      step();
      push_pkt(3, 4, 8'h60);
      drive();
      run("t3a", 100);
      exp_pkt(0, 4, 8'h40);
      exp_pkt(3, 4, 8'h60);
      exp_pkt(0, 4, 8'h50);
      compare_stream(0, "t3a_fair");

      // ---- 3b: port 3 disabled never wins ----
      clear_log();
      port_enable = 4'b0111;
      push_pkt(0, 4, 8'h70);
      push_pkt(0, 4, 8'h74);
      push_pkt(3, 4, 8'h78);
      drive();
      repeat (20) step();
      exp_pkt(0, 4, 8'h70);
      exp_pkt(0, 4, 8'h74);
      compare_stream(0, "t3b_disabled");
      check("t3b_port3_untouched", wp[3] - rp[3], 4);
      clear_log();
      port_enable = 4'hF;
      drive();
      run("t3c", 50);
      exp_pkt(3, 4, 8'h78);
      compare_stream(0, "t3c_reenabled");

      // ---- 4: oversize truncation on the 16-byte instance ----
      clear_log();
      push_pkt(1, 20, 8'h80);
      drive();
      run("t4", 100);
      exp_pkt(1, 16, 8'h80);
      compare_stream(1, "t4_small_trunc");
      check("t4_small_err_pulses", count_err(1), 1);
      check("t4_small_err_port",   log_b[log_b.size()-1].ep, 1);
      exp_q.delete();
      exp_pkt(1, 20, 8'h80);
      compare_stream(0, "t4_default_full");
      check("t4_default_no_err", count_err(0), 0);

      clear_log();
      push_pkt(1, 16, 8'h90);
      drive();
      run("t4b", 100);
      exp_pkt(1, 16, 8'h90);
      compare_stream(1, "t4b_exact_max");
      check("t4b_no_err",        count_err(1), 0);
      check("t4b_err_port_held", log_b[log_b.size()-1].ep, 1);

      // ---- 5: input gap holds the grant against port 2 ----
      clear_log();
      push_pkt(0, 8, 8'hA0);
      drive();
      repeat (4) step();
      hold[0] = 1'b1;
      push_pkt(2, 4, 8'hB0);
      drive();
      repeat (3) step();
      hold[0] = 1'b0;
      drive();
      run("t5", 100);
      check("t5_before_gap", {log_a[3].v, log_a[3].d}, {1'b1, 8'hA2});
      gaps = int'(log_a[4].v) + int'(log_a[5].v) + int'(log_a[6].v);
      check("t5_gap_valid_count", gaps, 0);
      check("t5_after_gap", {log_a[7].v, log_a[7].p, log_a[7].d}, {1'b1, 2'd0, 8'hA3});
      exp_pkt(0, 8, 8'hA0);
      exp_pkt(2, 4, 8'hB0);
      compare_stream(0, "t5");

      // ---- 6: asynchronous reset mid-packet ----
      clear_log();
      push_pkt(1, 10, 8'hC0);
      drive();
      repeat (4) step();
      check("t6_pre_rst_streaming", {m_tvalid_a, m_port_a}, {1'b1, 2'd1});
      rst_n = 1'b0;
      #1;
      check("t6_rst_s_tready",   s_tready_a, 0);
      check("t6_rst_s_tready_b", s_tready_b, 0);
      check("t6_rst_m_tvalid",   m_tvalid_a, 0);
      check("t6_rst_m_tdata",    m_tdata_a, 0);
      check("t6_rst_m_tlast",    m_tlast_a, 0);
      check("t6_rst_m_port",     m_port_a, 0);
      check("t6_rst_err_port_b", err_port_b, 0);
      for (int i = 0; i < NP; i++) begin
         wp[i] = 0; rp[i] = 0;
      end
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_log();
      push_pkt(0, 2, 8'hD0);
      push_pkt(1, 2, 8'hD4);
      push_pkt(2, 2, 8'hD8);
      push_pkt(3, 2, 8'hDC);
      drive();
      run("t6", 100);
      exp_pkt(0, 2, 8'hD0);
      exp_pkt(1, 2, 8'hD4);
      exp_pkt(2, 2, 8'hD8);
      exp_pkt(3, 2, 8'hDC);
      compare_stream(0, "t6_post_rst_order");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_feed_port_arbiter

// File: doc/feed_port_arbiter.md
Name: feed_port_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one byte-stream parser between NUM_PORTS MAC receive ports (A/B feed lines, redundant links).
- Sits between the per-port MAC byte streams and the parser input (tdata/tvalid/tlast). The parser has no backpressure, so this block applies backpressure upstream.
- Guarantees whole-packet atomicity and tags each forwarded byte with its source port.
- Truncates runaway (oversize or missing-tlast) packets so a faulty link cannot starve the other ports.

Parameters:
- NUM_PORTS, 4, number of input byte-stream ports (2..8).
- MAX_PKT_BYTES, 1530, maximum bytes forwarded per packet, including preamble/SFD (8 + 1522).
- PORT_W, $clog2(NUM_PORTS), width of the port tag (localparam).
- CNT_W, $clog2(MAX_PKT_BYTES+1), width of the byte counter (localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- port_enable  in  NUM_PORTS  per-port arbitration enable (config)
- s_tdata  in  NUM_PORTS*8  input bytes; port i occupies [8i+7:8i]
- s_tvalid  in  NUM_PORTS  per-port byte valid
- s_tlast  in  NUM_PORTS  per-port last byte of packet
- s_tready  out  NUM_PORTS  per-port accept
- m_tdata  out  8  byte to parser
- m_tvalid  out  1  byte valid to parser
- m_tlast  out  1  last byte of forwarded packet
- m_port  out  PORT_W  source port of the current m_ byte
- err_oversize  out  1  one-cycle pulse when a packet is truncated
- err_port  out  PORT_W  port that caused the last truncation (held until the next one)

Behaviour:
- Reset values:
  - m_tdata=0, m_tvalid=0, m_tlast=0, m_port=0.
  - err_oversize=0, err_port=0.
  - s_tready=0.
  - state=IDLE, grant=0, byte_cnt=0.
  - last_grant=NUM_PORTS-1, so port 0 has first priority.
- Reset is asynchronous. Asserting it mid-packet abandons the packet: outputs take reset values immediately, and no completion or tlast is emitted.
- A beat is accepted when s_tvalid[g] && s_tready[g].
- All m_* outputs and err_* outputs are registered. An accepted beat appears on m_* on the next cycle.
- s_tready is combinational from state and grant only, never from s_tvalid. At most one bit is high at a time.
- State machine states: IDLE, STREAM, DRAIN.
- IDLE:
  - s_tready=0, m_tvalid=0.
  - Requesters are s_tvalid & port_enable.
  - Winner is the first requester searching from last_grant+1 upward, wrapping modulo NUM_PORTS.
  - If any requester exists: grant<=winner, byte_cnt<=0, go to STREAM.
  - port_enable is sampled only here; disabling a port mid-packet does not cut that packet.
- STREAM:
  - s_tready[grant]=1.
  - On an accepted beat: m_tdata<=byte, m_tvalid<=1, m_port<=grant, byte_cnt<=byte_cnt+1.
  - If tlast: m_tlast<=1, last_grant<=grant, go to IDLE.
  - Else if byte_cnt==MAX_PKT_BYTES-1: m_tlast<=1, err_oversize<=1, err_port<=grant, last_grant<=grant, go to DRAIN.
  - No accepted beat: m_tvalid<=0. Other ports stay blocked, since the grant holds across input gaps.
- DRAIN:
  - s_tready[grant]=1, m_tvalid=0.
  - Accepted bytes are discarded.
  - On an accepted tlast, go to IDLE.
- Boundary cases:
  - A packet of exactly MAX_PKT_BYTES bytes with tlast on the final byte is normal: no error, no DRAIN.
  - A 1-byte packet (tlast on the first beat) is valid.
- Latency:
  - s_tvalid rising on an idle arbiter gives arbitration in cycle T, first accept in T+1, m_tvalid in T+2.
  - Back-to-back packets are separated by exactly 1 idle cycle on m_tvalid (the IDLE arbitration cycle).
- Simultaneous requests resolve by the round-robin rule only. A port continuously requesting cannot win twice while another enabled port is pending.

Decomposition:
- feed_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, STREAM, DRAIN}
  - constants DEFAULT_NUM_PORTS=4 and DEFAULT_MAX_PKT_BYTES=1530
- Sub-module rr_arbiter: combinational rotate-priority pick.
  - Inputs: req[NUM_PORTS] and last_grant.
  - Outputs: winner[PORT_W] and any_req.
  - It is reused by later shared-resource blocks.

Test Plan:
1. Port 0 sends a 64-byte packet (00..3F), other ports idle -> m_tdata 00..3F in order, m_port=0 throughout, m_tlast only on 3F, first m_tvalid 2 cycles after s_tvalid[0].
2. Ports 0, 1, 2 all assert tvalid in the same cycle, each with a 10-byte packet -> packets output in order 0, 1, 2, one m_tvalid-low cycle between them, no interleaving.
3. Port 0 streams packets back-to-back while port 3 is pending -> after port 0's packet completes, port 3 is granted before port 0 again. With port_enable=4'b0111, port 3 is never granted.
4. MAX_PKT_BYTES=16, port 1 sends 20 bytes -> 16 bytes output with m_tlast on byte 16, err_oversize high 1 cycle, err_port=1, remaining 4 bytes accepted and not output, then IDLE. A separate 16-byte packet with tlast on byte 16 -> no error.
5. The granted port drops s_tvalid for 3 cycles mid-packet while port 2 requests -> m_tvalid low for 3 cycles, port 2 not granted until the first packet's tlast.
6. rst_n asserted mid-packet -> s_tready and all outputs go to reset values immediately. After release, port 0 wins the first arbitration when all ports request.
